// File: rtl/jtdc_bus_pkg.sv
// jtdc_bus_pkg: shared AXI response codes, bus widths and sequencer states for the jTDC register bus
package jtdc_bus_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int STATUS_ADDR = 0;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_STROBE,
    ST_WR_RESP,
    ST_RD_STROBE,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_t;
endpackage

// File: rtl/axil_bus_sequencer.sv
// axil_bus_sequencer: AXI4-Lite slave (s_axil_*) driving the jTDC register bus (addressbus, databus_out/in, writesignal, readsignal; statusregister answers word 0)
module axil_bus_sequencer
  import jtdc_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_LSB = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [31:0]       s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [DATA_W-1:0] s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [31:0]       s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [DATA_W-1:0] s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  input  logic [DATA_W-1:0] statusregister,
  output logic [ADDR_W-1:0] addressbus,
  output logic [DATA_W-1:0] databus_out,
  input  logic [DATA_W-1:0] databus_in,
  output logic              writesignal,
  output logic              readsignal
);
  state_t state_q, state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic [31:ADDR_LSB] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d, rdata_q, rdata_d, databus_out_q, databus_out_d;
  logic [3:0] w_strb_q, w_strb_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] addressbus_q, addressbus_d;
  logic [1:0] resp_q, resp_d;
  logic last_wr_q, last_wr_d, status_q, status_d;
  logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic aw_hs, w_hs, ar_hs, wr_el, rd_el, grant_wr, grant_rd, aw_err, w_err, ar_err;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};
  assign aw_hs = s_axil_awvalid & awready_q;
  assign w_hs = s_axil_wvalid & wready_q;
  assign ar_hs = s_axil_arvalid & arready_q;
  assign aw_addr_d = aw_hs ? s_axil_awaddr[31:ADDR_LSB] : aw_addr_q;
  assign ar_addr_d = ar_hs ? s_axil_araddr[31:ADDR_LSB] : ar_addr_q;
  assign w_data_d = w_hs ? s_axil_wdata : w_data_q;
  assign w_strb_d = w_hs ? s_axil_wstrb : w_strb_q;
  // Eligibility includes channels handshaking this cycle so a grant costs no extra idle cycle.
  assign wr_el = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign rd_el = ar_held_q | ar_hs;
  assign grant_wr = wr_el & (!rd_el | !last_wr_q);
  assign grant_rd = rd_el & !grant_wr;
  assign aw_err = |aw_addr_d[31:ADDR_LSB+ADDR_W];
  assign ar_err = |ar_addr_d[31:ADDR_LSB+ADDR_W];
  assign w_err = w_strb_d != 4'hF;
  always_comb begin
    state_d = state_q;
    aw_held_d = aw_held_q | aw_hs;
    w_held_d = w_held_q | w_hs;
    ar_held_d = ar_held_q | ar_hs;
    last_wr_d = last_wr_q;
    cnt_d = cnt_q;
    addressbus_d = addressbus_q;
    databus_out_d = databus_out_q;
    rdata_d = rdata_q;
    resp_d = resp_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE:
        if (grant_wr) begin
          last_wr_d = 1'b1;
          resp_d = aw_err ? RESP_DECERR : w_err ? RESP_SLVERR : RESP_OKAY;
          state_d = (aw_err | w_err) ? ST_WR_RESP : ST_WR_STROBE;
          addressbus_d = (aw_err | w_err) ? addressbus_q : aw_addr_d[ADDR_LSB+ADDR_W-1:ADDR_LSB];
          databus_out_d = (aw_err | w_err) ? databus_out_q : w_data_d;
        end else if (grant_rd) begin
          last_wr_d = 1'b0;
          resp_d = ar_err ? RESP_DECERR : RESP_OKAY;
          state_d = ar_err ? ST_RD_RESP : ST_RD_STROBE;
          rdata_d = '0;
          addressbus_d = ar_err ? addressbus_q : ar_addr_d[ADDR_LSB+ADDR_W-1:ADDR_LSB];
          status_d = ar_addr_d[ADDR_LSB+ADDR_W-1:ADDR_LSB] == ADDR_W'(STATUS_ADDR);
        end
      ST_WR_STROBE: state_d = ST_WR_RESP;
      ST_WR_RESP:
        if (s_axil_bready) begin
          aw_held_d = 1'b0;
          w_held_d = 1'b0;
          state_d = ST_IDLE;
        end
      ST_RD_STROBE: begin
        cnt_d = 4'(READ_LATENCY - 1);
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          rdata_d = status_q ? statusregister : databus_in;
          state_d = ST_RD_RESP;
        end
      end
      ST_RD_RESP:
        if (s_axil_rready) begin
          ar_held_d = 1'b0;
          state_d = ST_IDLE;
        end
      default: state_d = ST_IDLE;
    endcase
  end
  // Readys are registered so they stay low throughout reset and rise one cycle after release.
  assign awready_d = (state_d == ST_IDLE) & !aw_held_d;
  assign wready_d = (state_d == ST_IDLE) & !w_held_d;
  assign arready_d = (state_d == ST_IDLE) & !ar_held_d;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      ar_held_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      last_wr_q <= 1'b0;
      cnt_q <= '0;
      addressbus_q <= '0;
      databus_out_q <= '0;
      rdata_q <= '0;
      resp_q <= RESP_OKAY;
      status_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      ar_held_q <= ar_held_d;
      aw_addr_q <= aw_addr_d;
      ar_addr_q <= ar_addr_d;
      w_data_q <= w_data_d;
      w_strb_q <= w_strb_d;
      last_wr_q <= last_wr_d;
      cnt_q <= cnt_d;
      addressbus_q <= addressbus_d;
      databus_out_q <= databus_out_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      status_q <= status_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      arready_q <= arready_d;
    end
  end
  assign s_axil_awready = awready_q;
  assign s_axil_wready = wready_q;
  assign s_axil_arready = arready_q;
  assign s_axil_bvalid = state_q == ST_WR_RESP;
  assign s_axil_rvalid = state_q == ST_RD_RESP;
  assign s_axil_bresp = resp_q;
  assign s_axil_rresp = resp_q;
  assign s_axil_rdata = rdata_q;
  assign writesignal = state_q == ST_WR_STROBE;
  assign readsignal = (state_q == ST_RD_STROBE) & !status_q;
  assign addressbus = addressbus_q;
  assign databus_out = databus_out_q;
endmodule

// File: tb/tb_axil_bus_sequencer.sv
// tb_axil_bus_sequencer: table-driven and directed checks of the AXI4-Lite register bus sequencer
module tb_axil_bus_sequencer;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0, s_axil_rdata;
  logic [3:0] s_axil_wstrb = '0;
  logic s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_bready = 1'b0, s_axil_arvalid = 1'b0, s_axil_rready = 1'b0;
  logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0] s_axil_bresp, s_axil_rresp;
  logic [31:0] statusregister = 32'h0000_0101, databus_out, databus_in, bus_val = '0;
  logic [15:0] addressbus;
  logic writesignal, readsignal;
  logic [1:0] rs_pipe;
  int n_cmp = 0, n_fail = 0;
  axil_bus_sequencer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .statusregister(statusregister), .addressbus(addressbus), .databus_out(databus_out), .databus_in(databus_in),
    .writesignal(writesignal), .readsignal(readsignal)
  );
  always #5 sys_clk = ~sys_clk;
  // Register file model: answers exactly two cycles after the read strobe, garbage otherwise.
  always @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) rs_pipe <= 2'b00;
    else rs_pipe <= {rs_pipe[0], readsignal};
  assign databus_in = rs_pipe[1] ? bus_val : 32'hBAD0_BAD0;
  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    int hold;
    logic [1:0] resp;
    int strobes;
    logic [15:0] baddr;
    logic [31:0] bdata;
    int lat;
  } vec_t;
  vec_t vecs[8];
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [95:0] all_outs();
    return {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, s_axil_arready, s_axil_rvalid,
            s_axil_rresp, s_axil_rdata, writesignal, readsignal, addressbus, databus_out};
  endfunction
  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
  endtask
  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r,
                           output int ns, output logic [15:0] ba, output logic [31:0] bd, output int lat);
    int n = 0;
    s_axil_awaddr = a;
    s_axil_wdata = d;
    s_axil_wstrb = s;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid = 1'b1;
    while (!(s_axil_awready && s_axil_wready) && n < 20) begin tick(); n++; end
    tick();
    s_axil_awvalid = 1'b0;
    s_axil_wvalid = 1'b0;
    ns = 0; lat = 1; ba = '0; bd = '0;
    while (!s_axil_bvalid && lat < 50) begin
      if (writesignal) begin ns++; ba = addressbus; bd = databus_out; end
      tick();
      lat++;
    end
    r = s_axil_bresp;
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
  endtask
  task automatic run_read(input logic [31:0] a, input logic [31:0] bv, input int hold, output logic [1:0] r,
                          output int ns, output logic [15:0] ba, output logic [31:0] rd, output int lat, output int unstable);
    int n = 0;
    bus_val = bv;
    s_axil_araddr = a;
    s_axil_arvalid = 1'b1;
    while (!s_axil_arready && n < 20) begin tick(); n++; end
    tick();
    s_axil_arvalid = 1'b0;
    ns = 0; lat = 1; ba = '0; unstable = 0;
    while (!s_axil_rvalid && lat < 50) begin
      if (readsignal) begin ns++; ba = addressbus; end
      tick();
      lat++;
    end
    rd = s_axil_rdata;
    r = s_axil_rresp;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!s_axil_rvalid || s_axil_rdata !== rd || s_axil_rresp !== r) unstable++;
    end
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;
  endtask
  task automatic contend(input logic [31:0] wa, input logic [31:0] ra, output int first, output int nw, output int nr);
    int n = 0;
    s_axil_awaddr = wa;
    s_axil_wdata = 32'h0000_00C0;
    s_axil_wstrb = 4'hF;
    s_axil_araddr = ra;
    bus_val = 32'h0000_00D0;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid = 1'b1;
    s_axil_arvalid = 1'b1;
    while (!(s_axil_awready && s_axil_wready && s_axil_arready) && n < 20) begin tick(); n++; end
    tick();
    s_axil_awvalid = 1'b0;
    s_axil_wvalid = 1'b0;
    s_axil_arvalid = 1'b0;
    first = 0; nw = 0; nr = 0;
    for (int i = 0; i < 40; i++) begin
      s_axil_bready = s_axil_bvalid;
      s_axil_rready = s_axil_rvalid;
      if (writesignal) begin nw++; if (first == 0) first = 1; end
      if (readsignal) begin nr++; if (first == 0) first = 2; end
      tick();
    end
    s_axil_bready = 1'b0;
    s_axil_rready = 1'b0;
  endtask
  initial begin
    logic [1:0] r;
    int ns, lat, unst, first, nw, nr, act;
    logic [15:0] ba;
    logic [31:0] bd;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, 1, 16'h0004, 32'hDEAD_BEEF, 2};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h1234_5678, 4'h0, 5, 2'b00, 1, 16'h0008, 32'h1234_5678, 4};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h7777_7777, 4'h0, 0, 2'b00, 0, 16'h0000, 32'h0000_0101, 4};
    vecs[3] = '{1'b0, 32'h0004_0000, 32'h7777_7777, 4'h0, 0, 2'b11, 0, 16'h0000, 32'h0000_0000, 1};
    vecs[4] = '{1'b1, 32'h0000_0014, 32'h1111_2222, 4'h3, 0, 2'b10, 0, 16'h0000, 32'h0000_0000, 1};
    vecs[5] = '{1'b1, 32'h0004_0010, 32'h3333_4444, 4'hF, 0, 2'b11, 0, 16'h0000, 32'h0000_0000, 1};
    vecs[6] = '{1'b1, 32'h0003_FFFC, 32'hA5A5_0001, 4'hF, 0, 2'b00, 1, 16'hFFFF, 32'hA5A5_0001, 2};
    vecs[7] = '{1'b0, 32'h0003_FFFC, 32'hCAFE_F00D, 4'h0, 2, 2'b00, 1, 16'hFFFF, 32'hCAFE_F00D, 4};
    tick();
    tick();
    chk("reset_outputs", all_outs(), '0);
    sys_rst = 1'b0;
    chk("readys_low_at_release", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    tick();
    chk("readys_after_release", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        run_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, ns, ba, bd, lat);
        chk($sformatf("v%0d_bresp", i), r, vecs[i].resp);
        chk($sformatf("v%0d_wstrobes", i), ns, vecs[i].strobes);
        chk($sformatf("v%0d_blat", i), lat, vecs[i].lat);
        if (vecs[i].strobes > 0) begin
          chk($sformatf("v%0d_waddr", i), ba, vecs[i].baddr);
          chk($sformatf("v%0d_wdata", i), bd, vecs[i].bdata);
        end
        chk($sformatf("v%0d_bvalid_drop", i), s_axil_bvalid, 1'b0);
      end else begin
        run_read(vecs[i].addr, vecs[i].data, vecs[i].hold, r, ns, ba, bd, lat, unst);
        chk($sformatf("v%0d_rresp", i), r, vecs[i].resp);
        chk($sformatf("v%0d_rstrobes", i), ns, vecs[i].strobes);
        chk($sformatf("v%0d_rlat", i), lat, vecs[i].lat);
        chk($sformatf("v%0d_rdata", i), bd, vecs[i].bdata);
        if (vecs[i].strobes > 0) chk($sformatf("v%0d_raddr", i), ba, vecs[i].baddr);
        if (vecs[i].hold > 0) chk($sformatf("v%0d_hold_unstable", i), unst, 0);
        chk($sformatf("v%0d_rvalid_drop", i), s_axil_rvalid, 1'b0);
      end
    end
    s_axil_wdata = 32'h55AA_55AA;
    s_axil_wstrb = 4'hF;
    s_axil_wvalid = 1'b1;
    chk("early_w_wready", s_axil_wready, 1'b1);
    tick();
    s_axil_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("early_w_wait%0d", i), {s_axil_awready, s_axil_wready, writesignal}, 3'b100);
      tick();
    end
    s_axil_awaddr = 32'h0000_0024;
    s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    ns = 0; lat = 1; ba = '0; bd = '0;
    while (!s_axil_bvalid && lat < 50) begin
      if (writesignal) begin ns++; ba = addressbus; bd = databus_out; end
      tick();
      lat++;
    end
    chk("early_w_strobes", ns, 1);
    chk("early_w_addr", ba, 16'h0009);
    chk("early_w_data", bd, 32'h55AA_55AA);
    chk("early_w_lat", lat, 2);
    chk("early_w_bresp", s_axil_bresp, 2'b00);
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    do_reset();
    contend(32'h0000_0030, 32'h0000_0034, first, nw, nr);
    chk("contend1_first_is_write", first, 1);
    chk("contend1_strobes", {nw[7:0], nr[7:0]}, 16'h0101);
    run_write(32'h0000_0038, 32'h0000_0099, 4'hF, r, ns, ba, bd, lat);
    chk("solo_write_strobes", ns, 1);
    contend(32'h0000_003C, 32'h0000_0040, first, nw, nr);
    chk("contend2_first_is_read", first, 2);
    chk("contend2_strobes", {nw[7:0], nr[7:0]}, 16'h0101);
    bus_val = 32'h0F0F_0F0F;
    s_axil_araddr = 32'h0000_0020;
    s_axil_arvalid = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    chk("rst_mid_in_strobe", readsignal, 1'b1);
    tick();
    #2 sys_rst = 1'b1;
    #1 chk("rst_mid_outputs", all_outs(), '0);
    tick();
    sys_rst = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_axil_rvalid || s_axil_bvalid || readsignal || writesignal) act++;
      tick();
    end
    chk("rst_mid_no_activity", act, 0);
    chk("rst_mid_readys", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
